// File: rtl/regex_pc_scheduler_if.sv
// Handshake bundle between the regex thread scheduler, the string source and the CPU.
interface regex_pc_scheduler_if #(
  parameter int unsigned PC_WIDTH        = 8,
  parameter int unsigned CHARACTER_WIDTH = 8
);
  logic                       start;
  logic [PC_WIDTH-1:0]        start_pc;
  logic                       char_in_valid;
  logic [CHARACTER_WIDTH-1:0] char_in;
  logic                       char_in_last;
  logic                       char_in_ready;
  logic [CHARACTER_WIDTH-1:0] current_character;
  logic                       cpu_input_pc_valid;
  logic [PC_WIDTH-1:0]        cpu_input_pc;
  logic                       cpu_input_pc_ready;
  logic                       cpu_output_pc_valid;
  logic [PC_WIDTH-1:0]        cpu_output_pc;
  logic                       cpu_output_pc_is_directed_to_current;
  logic                       cpu_output_pc_ready;
  logic                       cpu_accepts;
  logic                       cpu_running;
  logic                       busy;
  logic                       done;
  logic                       accepted;
  logic                       overflow;

  modport master (
    output start, start_pc, char_in_valid, char_in, char_in_last,
           cpu_input_pc_ready, cpu_output_pc_valid, cpu_output_pc,
           cpu_output_pc_is_directed_to_current, cpu_accepts, cpu_running,
    input  char_in_ready, current_character, cpu_input_pc_valid, cpu_input_pc,
           cpu_output_pc_ready, busy, done, accepted, overflow
  );

  modport slave (
    input  start, start_pc, char_in_valid, char_in, char_in_last,
           cpu_input_pc_ready, cpu_output_pc_valid, cpu_output_pc,
           cpu_output_pc_is_directed_to_current, cpu_accepts, cpu_running,
    output char_in_ready, current_character, cpu_input_pc_valid, cpu_input_pc,
           cpu_output_pc_ready, busy, done, accepted, overflow
  );
endinterface

// File: rtl/regex_pc_scheduler.sv
// Thread scheduler for regex_cpu_pipelined: two ping-pong PC FIFOs (current / next character),
// character fetch, FIFO swap on drain and match / no-match reporting.
module regex_pc_scheduler #(
  parameter int unsigned PC_WIDTH              = 8,
  parameter int unsigned CHARACTER_WIDTH       = 8,
  parameter int unsigned FIFO_WIDTH_POWER_OF_2 = 2
) (
  input logic                 clk,
  input logic                 reset,
  regex_pc_scheduler_if.slave bus
);
  localparam int unsigned PW    = FIFO_WIDTH_POWER_OF_2;
  localparam int unsigned CW    = FIFO_WIDTH_POWER_OF_2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_WIDTH_POWER_OF_2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_ADVANCE, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic                       cur_sel_q, cur_sel_d;
  logic [CHARACTER_WIDTH-1:0] char_q, char_d;
  logic                       last_q, last_d;
  logic                       accepted_q, accepted_d;
  logic                       overflow_q, overflow_d;
  logic [PW-1:0]              rd_ptr_q [2];
  logic [PW-1:0]              rd_ptr_d [2];
  logic [PW-1:0]              wr_ptr_q [2];
  logic [PW-1:0]              wr_ptr_d [2];
  logic [CW-1:0]              cnt_q    [2];
  logic [CW-1:0]              cnt_d    [2];
  logic [PC_WIDTH-1:0]        mem_q    [2][DEPTH];

  logic [1:0]                 wr_en, pop_en;
  logic [PW-1:0]              wr_addr [2];
  logic [PC_WIDTH-1:0]        wr_data;
  logic                       flush, pop, tgt, cur, nxt;

  // Next-state, FIFO control and status updates.
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    char_d     = char_q;
    last_d     = last_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    wr_addr    = wr_ptr_q;
    wr_en      = 2'b00;
    pop_en     = 2'b00;
    wr_data    = bus.cpu_output_pc;
    flush      = 1'b0;
    pop        = 1'b0;
    cur        = cur_sel_q;
    nxt        = ~cur_sel_q;
    tgt        = bus.cpu_output_pc_is_directed_to_current ? cur : nxt;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          flush      = 1'b1;
          wr_en[0]   = 1'b1;
          wr_data    = bus.start_pc;
          cur_sel_d  = 1'b0;
          accepted_d = 1'b0;
          overflow_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.char_in_valid) begin
          char_d  = bus.char_in;
          last_d  = bus.char_in_last;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        pop         = (cnt_q[cur] != '0) && bus.cpu_input_pc_ready;
        pop_en[cur] = pop;
        // A push into a full FIFO is dropped rather than stalling the CPU loop.
        if (bus.cpu_output_pc_valid) begin
          if (cnt_q[tgt] == CW'(DEPTH)) overflow_d = 1'b1;
          else                          wr_en[tgt] = 1'b1;
        end
        if (bus.cpu_accepts) begin
          accepted_d = 1'b1;
          state_d    = S_DONE;
        end else if ((cnt_q[cur] == '0) && !bus.cpu_running &&
                     !bus.cpu_output_pc_valid && !pop) begin
          if ((cnt_q[nxt] == '0) || last_q) begin
            accepted_d = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d    = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        cur_sel_d = ~cur_sel_q;
        state_d   = S_FETCH;
      end
      S_DONE: begin
        flush   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int f = 0; f < 2; f++) begin
      if (flush) begin
        rd_ptr_d[f] = '0;
        wr_addr[f]  = '0;
        cnt_d[f]    = '0;
      end
      rd_ptr_d[f] = rd_ptr_d[f] + PW'(pop_en[f]);
      wr_ptr_d[f] = wr_addr[f] + PW'(wr_en[f]);
      cnt_d[f]    = cnt_d[f] + CW'(wr_en[f]) - CW'(pop_en[f]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cur_sel_q  <= 1'b0;
      char_q     <= '0;
      last_q     <= 1'b0;
      accepted_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '{default: '0};
      wr_ptr_q   <= '{default: '0};
      cnt_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      char_q     <= char_d;
      last_q     <= last_d;
      accepted_q <= accepted_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // PC storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int f = 0; f < 2; f++) begin
      if (wr_en[f]) mem_q[f][wr_addr[f]] <= wr_data;
    end
  end

  assign bus.char_in_ready       = (state_q == S_FETCH);
  assign bus.current_character   = char_q;
  assign bus.cpu_input_pc_valid  = (state_q == S_RUN) && (cnt_q[cur_sel_q] != '0);
  assign bus.cpu_input_pc        = bus.cpu_input_pc_valid ?
                                   mem_q[cur_sel_q][rd_ptr_q[cur_sel_q]] : '0;
  assign bus.cpu_output_pc_ready = (state_q == S_RUN);
  assign bus.busy                = (state_q != S_IDLE);
  assign bus.done                = (state_q == S_DONE);
  assign bus.accepted            = accepted_q;
  assign bus.overflow            = overflow_q;
endmodule

// File: tb/tb_regex_pc_scheduler.sv
// Directed bench for regex_pc_scheduler; the bench plays the role of the CPU and string source.
module tb_regex_pc_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regex_pc_scheduler_if #(.PC_WIDTH(8), .CHARACTER_WIDTH(8)) bus ();

  regex_pc_scheduler #(
    .PC_WIDTH(8), .CHARACTER_WIDTH(8), .FIFO_WIDTH_POWER_OF_2(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.start = 1'b0; bus.start_pc = 8'h00;
    bus.char_in_valid = 1'b0; bus.char_in = 8'h00; bus.char_in_last = 1'b0;
    bus.cpu_input_pc_ready = 1'b0; bus.cpu_output_pc_valid = 1'b0; bus.cpu_output_pc = 8'h00;
    bus.cpu_output_pc_is_directed_to_current = 1'b0;
    bus.cpu_accepts = 1'b0; bus.cpu_running = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},      32'(bus.busy), 0);
    chk({tag, ".done"},      32'(bus.done), 0);
    chk({tag, ".accepted"},  32'(bus.accepted), 0);
    chk({tag, ".overflow"},  32'(bus.overflow), 0);
    chk({tag, ".chr_rdy"},   32'(bus.char_in_ready), 0);
    chk({tag, ".in_vld"},    32'(bus.cpu_input_pc_valid), 0);
    chk({tag, ".in_pc"},     32'(bus.cpu_input_pc), 0);
    chk({tag, ".out_rdy"},   32'(bus.cpu_output_pc_ready), 0);
    chk({tag, ".cur_char"},  32'(bus.current_character), 0);
  endtask

  // Start a match and feed one character; leaves the DUT in RUN.
  task automatic begin_match(input logic [7:0] pc, input logic [7:0] ch, input logic last);
    bus.start = 1'b1; bus.start_pc = pc;
    tick();
    bus.start = 1'b0;
    bus.char_in_valid = 1'b1; bus.char_in = ch; bus.char_in_last = last;
    tick();
    bus.char_in_valid = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b0;
    #1;
    chk_all_zero("rst");
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("idle.busy", 32'(bus.busy), 0);

    // 1: single char "a" (last); CPU sends 0x06 to next, never accepts.
    bus.start = 1'b1; bus.start_pc = 8'h05;
    tick();
    bus.start = 1'b0;
    chk("t1.fetch.chr_rdy", 32'(bus.char_in_ready), 1);
    chk("t1.fetch.busy",    32'(bus.busy), 1);
    bus.char_in_valid = 1'b1; bus.char_in = 8'h61; bus.char_in_last = 1'b1;
    tick();
    bus.char_in_valid = 1'b0;
    chk("t1.run.char",    32'(bus.current_character), 32'h61);
    chk("t1.run.in_vld",  32'(bus.cpu_input_pc_valid), 1);
    chk("t1.run.in_pc",   32'(bus.cpu_input_pc), 32'h05);
    chk("t1.run.out_rdy", 32'(bus.cpu_output_pc_ready), 1);
    chk("t1.run.chr_rdy", 32'(bus.char_in_ready), 0);
    bus.cpu_input_pc_ready = 1'b1; bus.cpu_running = 1'b1;
    tick();
    bus.cpu_input_pc_ready = 1'b0;
    chk("t1.popped.in_vld", 32'(bus.cpu_input_pc_valid), 0);
    bus.cpu_output_pc_valid = 1'b1; bus.cpu_output_pc = 8'h06;
    bus.cpu_output_pc_is_directed_to_current = 1'b0;
    tick();
    bus.cpu_output_pc_valid = 1'b0; bus.cpu_running = 1'b0;
    chk("t1.next_only.in_vld", 32'(bus.cpu_input_pc_valid), 0);
    tick();
    chk("t1.done",     32'(bus.done), 1);
    chk("t1.accepted", 32'(bus.accepted), 0);
    tick();
    chk("t1.idle.done", 32'(bus.done), 0);
    chk("t1.idle.busy", 32'(bus.busy), 0);

    // 2: "ab"; 0x01 goes to next on 'a', accepted while 0x01 runs on 'b'.
    begin_match(8'h00, 8'h61, 1'b0);
    chk("t2.run.in_pc", 32'(bus.cpu_input_pc), 32'h00);
    bus.cpu_input_pc_ready = 1'b1; bus.cpu_running = 1'b1;
    tick();
    bus.cpu_input_pc_ready = 1'b0;
    bus.cpu_output_pc_valid = 1'b1; bus.cpu_output_pc = 8'h01;
    bus.cpu_output_pc_is_directed_to_current = 1'b0;
    tick();
    bus.cpu_output_pc_valid = 1'b0; bus.cpu_running = 1'b0;
    tick();
    chk("t2.adv.busy",    32'(bus.busy), 1);
    chk("t2.adv.chr_rdy", 32'(bus.char_in_ready), 0);
    chk("t2.adv.done",    32'(bus.done), 0);
    tick();
    chk("t2.fetch.chr_rdy", 32'(bus.char_in_ready), 1);
    chk("t2.fetch.in_vld",  32'(bus.cpu_input_pc_valid), 0);
    bus.char_in_valid = 1'b1; bus.char_in = 8'h62; bus.char_in_last = 1'b1;
    tick();
    bus.char_in_valid = 1'b0;
    chk("t2.run2.char",   32'(bus.current_character), 32'h62);
    chk("t2.run2.in_vld", 32'(bus.cpu_input_pc_valid), 1);
    chk("t2.run2.in_pc",  32'(bus.cpu_input_pc), 32'h01);
    bus.cpu_input_pc_ready = 1'b1; bus.cpu_running = 1'b1;
    tick();
    bus.cpu_input_pc_ready = 1'b0; bus.cpu_accepts = 1'b1;
    tick();
    bus.cpu_accepts = 1'b0; bus.cpu_running = 1'b0;
    chk("t2.done",     32'(bus.done), 1);
    chk("t2.accepted", 32'(bus.accepted), 1);
    tick();
    chk("t2.idle.done",     32'(bus.done), 0);
    chk("t2.idle.accepted", 32'(bus.accepted), 1);

    // 3: five PCs to current while input is not ready; only four fit.
    begin_match(8'h10, 8'h78, 1'b1);
    chk("t3.start.accepted", 32'(bus.accepted), 0);
    bus.cpu_input_pc_ready = 1'b1; bus.cpu_running = 1'b1;
    tick();
    bus.cpu_input_pc_ready = 1'b0;
    bus.cpu_output_pc_is_directed_to_current = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3.push%0d.out_rdy", i), 32'(bus.cpu_output_pc_ready), 1);
      chk($sformatf("t3.push%0d.ovf", i), 32'(bus.overflow), 0);
      bus.cpu_output_pc_valid = 1'b1; bus.cpu_output_pc = 8'(8'h20 + i);
      tick();
    end
    bus.cpu_output_pc_valid = 1'b0;
    chk("t3.ovf", 32'(bus.overflow), 1);
    bus.cpu_input_pc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3.pop%0d.vld", i), 32'(bus.cpu_input_pc_valid), 1);
      chk($sformatf("t3.pop%0d.pc", i),  32'(bus.cpu_input_pc), 32'h20 + 32'(i));
      tick();
    end
    chk("t3.empty.vld", 32'(bus.cpu_input_pc_valid), 0);
    bus.cpu_input_pc_ready = 1'b0; bus.cpu_running = 1'b0;
    tick();
    chk("t3.done",     32'(bus.done), 1);
    chk("t3.done.ovf", 32'(bus.overflow), 1);
    tick();

    // 4: simultaneous push/pop of current at count 4 (push dropped) and count 2 (both apply).
    begin_match(8'h30, 8'h79, 1'b1);
    chk("t4.start.ovf", 32'(bus.overflow), 0);
    bus.cpu_running = 1'b1;
    bus.cpu_output_pc_is_directed_to_current = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.cpu_output_pc_valid = 1'b1; bus.cpu_output_pc = 8'(8'h30 + i);
      tick();
    end
    chk("t4.full.head", 32'(bus.cpu_input_pc), 32'h30);
    bus.cpu_output_pc = 8'h34; bus.cpu_input_pc_ready = 1'b1;
    tick();
    chk("t4.drop.ovf",  32'(bus.overflow), 1);
    chk("t4.drop.head", 32'(bus.cpu_input_pc), 32'h31);
    bus.cpu_output_pc_valid = 1'b0;
    tick();
    chk("t4.cnt2.head", 32'(bus.cpu_input_pc), 32'h32);
    bus.cpu_output_pc_valid = 1'b1; bus.cpu_output_pc = 8'h35;
    tick();
    bus.cpu_output_pc_valid = 1'b0;
    chk("t4.same.head0", 32'(bus.cpu_input_pc), 32'h33);
    tick();
    chk("t4.same.vld1",  32'(bus.cpu_input_pc_valid), 1);
    chk("t4.same.head1", 32'(bus.cpu_input_pc), 32'h35);
    tick();
    chk("t4.empty.vld", 32'(bus.cpu_input_pc_valid), 0);
    bus.cpu_input_pc_ready = 1'b0; bus.cpu_running = 1'b0;
    tick();
    chk("t4.done", 32'(bus.done), 1);
    tick();

    // 5: FETCH stall, start ignored in RUN, asynchronous reset mid-RUN.
    bus.start = 1'b1; bus.start_pc = 8'h40;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5.stall%0d.chr_rdy", i), 32'(bus.char_in_ready), 1);
      chk($sformatf("t5.stall%0d.in_vld", i),  32'(bus.cpu_input_pc_valid), 0);
      chk($sformatf("t5.stall%0d.out_rdy", i), 32'(bus.cpu_output_pc_ready), 0);
      tick();
    end
    bus.char_in_valid = 1'b1; bus.char_in = 8'h7a; bus.char_in_last = 1'b1;
    tick();
    bus.char_in_valid = 1'b0;
    chk("t5.run.in_pc", 32'(bus.cpu_input_pc), 32'h40);
    bus.cpu_running = 1'b1; bus.start = 1'b1; bus.start_pc = 8'h77;
    tick();
    bus.start = 1'b0;
    chk("t5.ign.chr_rdy", 32'(bus.char_in_ready), 0);
    chk("t5.ign.out_rdy", 32'(bus.cpu_output_pc_ready), 1);
    chk("t5.ign.in_pc",   32'(bus.cpu_input_pc), 32'h40);
    chk("t5.ign.char",    32'(bus.current_character), 32'h7a);
    quiet();
    reset = 1'b0;
    #1;
    chk_all_zero("t5.rst");
    #2;
    reset = 1'b1;
    tick();
    chk("t5.after.busy",    32'(bus.busy), 0);
    chk("t5.after.chr_rdy", 32'(bus.char_in_ready), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
